// File: rtl/l2_mem_responder.sv
// Main-memory responder for the L2 cache's memory-side port: latches a request,
// waits a programmable latency, then completes it with a one-cycle mem_ready pulse.
module l2_mem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_DEPTH     = 1024,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  proto_err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int OFS = $clog2(DATA_WIDTH / 8);
  localparam int IW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;

  state_t                state, state_next;
  logic [7:0]            cnt, cnt_next;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  latch_req, rd_done, wr_done, err_set;
  logic [IW-1:0]         req_idx;
  logic                  unused_addr;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Upper bits alias and byte-offset bits are dropped; only the word index is kept.
  assign req_idx     = mem_addr[OFS +: IW];
  assign unused_addr = ^mem_addr;
  assign busy        = (state != IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every variable driven here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    latch_req  = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_write) begin
          state_next = WRITE_WAIT;
          cnt_next   = 8'(WRITE_LATENCY - 1);
          latch_req  = 1'b1;
          err_set    = mem_read;
        end else if (mem_read) begin
          state_next = READ_WAIT;
          cnt_next   = 8'(READ_LATENCY - 1);
          latch_req  = 1'b1;
        end
      end
      READ_WAIT, WRITE_WAIT: begin
        err_set = mem_read | mem_write;
        if (cnt != 8'd0) begin
          cnt_next = cnt - 8'd1;
        end else begin
          state_next = IDLE;
          rd_done    = (state == READ_WAIT);
          wr_done    = (state == WRITE_WAIT);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      wdata       <= '0;
      mem_data_in <= '0;
      mem_ready   <= 1'b0;
      proto_err   <= 1'b0;
      rd_count    <= '0;
      wr_count    <= '0;
    end else begin
      mem_ready <= rd_done | wr_done;
      if (latch_req) begin
        idx   <= req_idx;
        wdata <= mem_data_out;
      end
      if (rd_done) mem_data_in <= mem[idx];
      if (err_set) proto_err <= 1'b1;
      if (rd_done && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (wr_done && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; an aborted
  // write never commits because wr_done depends on the reset FSM state.
  always_ff @(posedge clk) begin
    if (wr_done) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: instance 0 uses 4/4 latency, instance 1
// uses read latency 1 and write latency 2 for back-to-back and saturation runs.
module tb_l2_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        rd     [2];
  logic        wr     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdat   [2];
  logic [31:0] rdat   [2];
  logic        ready  [2];
  logic        bsy    [2];
  logic        perr   [2];
  logic [15:0] rdc    [2];
  logic [15:0] wrc    [2];

  int total = 0;
  int bad   = 0;

  l2_mem_responder #(.READ_LATENCY(4), .WRITE_LATENCY(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr[0]), .mem_data_out(wdat[0]),
    .mem_read(rd[0]), .mem_write(wr[0]), .mem_data_in(rdat[0]),
    .mem_ready(ready[0]), .busy(bsy[0]), .proto_err(perr[0]),
    .rd_count(rdc[0]), .wr_count(wrc[0])
  );

  l2_mem_responder #(.READ_LATENCY(1), .WRITE_LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(addr[1]), .mem_data_out(wdat[1]),
    .mem_read(rd[1]), .mem_write(wr[1]), .mem_data_in(rdat[1]),
    .mem_ready(ready[1]), .busy(bsy[1]), .proto_err(perr[1]),
    .rd_count(rdc[1]), .wr_count(wrc[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one request for a single sampling edge; starts and ends 1 time unit after an edge.
  task automatic issue(input int u, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
    rd[u]   = r;
    wr[u]   = w;
    addr[u] = a;
    wdat[u] = d;
    @(posedge clk); #1;
    rd[u] = 1'b0;
    wr[u] = 1'b0;
  endtask

  // Counts edges after the sampling edge until mem_ready, then checks pulse width.
  task automatic wait_ready(input int u, input int lat, input string tag);
    int k;
    check({tag, "_busy"}, bsy[u], 1'b1);
    for (k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (ready[u]) break;
    end
    check({tag, "_lat"}, k, lat);
    @(posedge clk); #1;
    check({tag, "_pulse"}, ready[u], 1'b0);
  endtask

  task automatic check_reset_outputs(input int u, input string tag);
    check({tag, "_ready"}, ready[u], 1'b0);
    check({tag, "_data"},  rdat[u],  32'h0);
    check({tag, "_busy"},  bsy[u],   1'b0);
    check({tag, "_perr"},  perr[u],  1'b0);
    check({tag, "_rdc"},   rdc[u],   16'h0);
    check({tag, "_wrc"},   wrc[u],   16'h0);
  endtask

  initial begin
    int n;
    int cyc;
    int edge_at;
    bit seen;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdat[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs(0, "rst0");
    check_reset_outputs(1, "rst1");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write then read, latency 4
    issue(0, 0, 1, 32'h40, 32'hDEADBEEF);
    wait_ready(0, 4, "wr40");
    check("wr40_wrc", wrc[0], 16'd1);
    check("wr40_data_held", rdat[0], 32'h0);
    issue(0, 1, 0, 32'h40, 32'h0);
    wait_ready(0, 4, "rd40");
    check("rd40_data", rdat[0], 32'hDEADBEEF);
    check("rd40_rdc", rdc[0], 16'd1);
    check("rd40_wrc", wrc[0], 16'd1);
    check("rd40_perr", perr[0], 1'b0);

    // Aliasing: upper address bits and byte offset are ignored
    issue(0, 0, 1, 32'h0000_0004, 32'h12345678);
    wait_ready(0, 4, "wr4");
    issue(0, 1, 0, 32'h0000_1004, 32'h0);
    wait_ready(0, 4, "rd1004");
    check("alias_data", rdat[0], 32'h12345678);
    issue(0, 1, 0, 32'h0000_1007, 32'h0);
    wait_ready(0, 4, "rd1007");
    check("alias_ofs_data", rdat[0], 32'h12345678);
    check("alias_rdc", rdc[0], 16'd3);

    // Latency 1 back-to-back reads on instance 1
    issue(1, 0, 1, 32'h0, 32'hA0);
    wait_ready(1, 2, "w1_0");
    issue(1, 0, 1, 32'h4, 32'hA1);
    wait_ready(1, 2, "w1_4");
    issue(1, 0, 1, 32'h8, 32'hA2);
    wait_ready(1, 2, "w1_8");
    for (int i = 0; i < 3; i++) begin
      rd[1]   = 1'b1;
      addr[1] = 32'(4 * i);
      @(posedge clk); #1;
      rd[1] = 1'b0;
      check($sformatf("b2b%0d_busy_hi", i), bsy[1], 1'b1);
      check($sformatf("b2b%0d_ready_lo", i), ready[1], 1'b0);
      @(posedge clk); #1;
      check($sformatf("b2b%0d_ready", i), ready[1], 1'b1);
      check($sformatf("b2b%0d_busy_lo", i), bsy[1], 1'b0);
      check($sformatf("b2b%0d_data", i), rdat[1], 32'hA0 + 32'(i));
    end
    @(posedge clk); #1;
    check("b2b_perr", perr[1], 1'b0);
    check("b2b_rdc", rdc[1], 16'd3);

    // Read request while in READ_WAIT is ignored and flagged
    rd[0]   = 1'b1;
    addr[0] = 32'h40;
    @(posedge clk); #1;
    check("inwait_busy", bsy[0], 1'b1);
    @(posedge clk); #1;
    rd[0] = 1'b0;
    check("inwait_perr", perr[0], 1'b1);
    n = 0;
    edge_at = 0;
    for (int k = 2; k <= 11; k++) begin
      @(posedge clk); #1;
      if (ready[0]) begin
        n++;
        if (edge_at == 0) edge_at = k;
      end
    end
    check("inwait_pulses", n, 1);
    check("inwait_lat", edge_at, 4);
    check("inwait_data", rdat[0], 32'hDEADBEEF);
    check("inwait_rdc", rdc[0], 16'd4);

    // Simultaneous read and write: write wins, read dropped
    issue(0, 1, 1, 32'h10, 32'hA5A5A5A5);
    wait_ready(0, 4, "both");
    check("both_wrc", wrc[0], 16'd3);
    check("both_rdc", rdc[0], 16'd4);
    check("both_perr", perr[0], 1'b1);
    issue(0, 1, 0, 32'h10, 32'h0);
    wait_ready(0, 4, "rd10");
    check("rd10_data", rdat[0], 32'hA5A5A5A5);
    check("rd10_rdc", rdc[0], 16'd5);

    // Reset in the middle of a write
    issue(0, 0, 1, 32'h20, 32'h11111111);
    wait_ready(0, 4, "wr20a");
    check("wr20a_wrc", wrc[0], 16'd4);
    issue(0, 0, 1, 32'h20, 32'h22222222);
    @(posedge clk); #1;
    check("abort_ready_pre", ready[0], 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "midrst");
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready[0]) seen = 1'b1;
    end
    check("abort_no_ready", seen, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 1, 0, 32'h20, 32'h0);
    wait_ready(0, 4, "rd20");
    check("rd20_data", rdat[0], 32'h11111111);
    check("rd20_rdc", rdc[0], 16'd1);
    check("rd20_wrc", wrc[0], 16'd0);

    // Read counter saturation on instance 1 (memory survives reset)
    rd[1]   = 1'b1;
    addr[1] = 32'h0;
    n   = 0;
    cyc = 0;
    while (n < 65537 && cyc < 140000) begin
      @(posedge clk); #1;
      cyc++;
      if (ready[1]) begin
        n++;
        if (n == 65534) check("sat_fffe", rdc[1], 16'hFFFE);
      end
    end
    rd[1] = 1'b0;
    check("sat_pulses", n, 65537);
    check("sat_rdc", rdc[1], 16'hFFFF);
    check("sat_wrc", wrc[1], 16'h0);
    check("sat_data", rdat[1], 32'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
